// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory signal bundle for the multicycle LEGv8 core.
// The control unit uses the master modport; the datapath/memory side uses slave.
interface multicycle_control_if;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  ALUControl;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        instr_done;
  logic        mem_timeout;
  logic        exc;
  logic [3:0]  state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output ALUControl, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
           mem_read, mem_write, reg_write, mem_to_reg, instr_done,
           mem_timeout, exc, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALUControl, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
           mem_read, mem_write, reg_write, mem_to_reg, instr_done,
           mem_timeout, exc, state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM control for the multicycle LEGv8 datapath: R 4, LDUR 5, STUR 4, CBZ 3 cycles; memory states stall on mem_ready.
// MULTICYCLE_ILLEGAL_TRAP_EN routes illegal opcodes to TRAP; otherwise they retire as a NOP from DECODE.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    R_WB   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    LD_WB  = 4'd6,
    MEM_WR = 4'd7,
    CBZ_EX = 4'd8,
    TRAP   = 4'd9
  } state_t;

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  logic is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_cbz, is_rtype;
  assign is_add   = (bus.opcode == 11'b10001011000);
  assign is_sub   = (bus.opcode == 11'b11001011000);
  assign is_and   = (bus.opcode == 11'b10001010000);
  assign is_orr   = (bus.opcode == 11'b10101010000);
  assign is_ldur  = (bus.opcode == 11'b11111000010);
  assign is_stur  = (bus.opcode == 11'b11111000000);
  assign is_cbz   = (bus.opcode[10:3] == 8'b10110100);
  assign is_rtype = is_add | is_sub | is_and | is_orr;

  logic mem_state, mem_wait;
  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign mem_wait  = mem_state && !bus.mem_ready;

  logic [3:0] alu_ctl;
  logic       src_a, pc_wr, ir_wr, mrd, mwr, reg_wr, m2r, done, exc_c;
  logic [1:0] src_b, pc_sel;

  always_comb begin
    state_nxt = state;
    alu_ctl   = 4'b0000;
    src_a     = 1'b0;
    src_b     = 2'b00;
    pc_wr     = 1'b0;
    pc_sel    = 2'b00;
    ir_wr     = 1'b0;
    mrd       = 1'b0;
    mwr       = 1'b0;
    reg_wr    = 1'b0;
    m2r       = 1'b0;
    done      = 1'b0;
    exc_c     = 1'b0;
    case (state)
      FETCH: begin
        mrd     = 1'b1;
        src_b   = 2'b01;
        alu_ctl = 4'b0010;
        if (bus.mem_ready) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        // Branch target is computed speculatively so CBZ_EX can load it from ALUOut.
        src_b   = 2'b11;
        alu_ctl = 4'b0010;
        if (is_rtype)               state_nxt = EXEC_R;
        else if (is_ldur || is_stur) state_nxt = ADDR;
        else if (is_cbz)             state_nxt = CBZ_EX;
        else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_nxt = TRAP;
`else
          done      = 1'b1;
          state_nxt = FETCH;
`endif
        end
      end
      EXEC_R: begin
        src_a = 1'b1;
        if (is_sub)      alu_ctl = 4'b0110;
        else if (is_and) alu_ctl = 4'b0000;
        else if (is_orr) alu_ctl = 4'b0001;
        else             alu_ctl = 4'b0010;
        state_nxt = R_WB;
      end
      R_WB: begin
        reg_wr    = 1'b1;
        done      = 1'b1;
        state_nxt = FETCH;
      end
      ADDR: begin
        src_a     = 1'b1;
        src_b     = 2'b10;
        alu_ctl   = 4'b0010;
        state_nxt = is_ldur ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mrd = 1'b1;
        if (bus.mem_ready) state_nxt = LD_WB;
      end
      LD_WB: begin
        reg_wr    = 1'b1;
        m2r       = 1'b1;
        done      = 1'b1;
        state_nxt = FETCH;
      end
      MEM_WR: begin
        mwr = 1'b1;
        if (bus.mem_ready) begin
          done      = 1'b1;
          state_nxt = FETCH;
        end
      end
      CBZ_EX: begin
        src_a     = 1'b1;
        alu_ctl   = 4'b0111;
        pc_sel    = 2'b01;
        pc_wr     = bus.zero;
        done      = 1'b1;
        state_nxt = FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      TRAP: begin
        exc_c     = 1'b1;
        pc_wr     = 1'b1;
        pc_sel    = 2'b10;
        done      = 1'b1;
        state_nxt = FETCH;
      end
`endif
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (mem_wait && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + CW'(1);
      if (mem_wait && wait_cnt == WAIT_MAX)
        timeout_q <= 1'b1;
    end
  end

  // Outputs are forced low combinationally so an aborted instruction writes nothing during reset.
  assign bus.ALUControl  = reset ? 4'b0000 : alu_ctl;
  assign bus.alu_src_a   = !reset && src_a;
  assign bus.alu_src_b   = reset ? 2'b00 : src_b;
  assign bus.pc_write    = !reset && pc_wr;
  assign bus.pc_src      = reset ? 2'b00 : pc_sel;
  assign bus.ir_write    = !reset && ir_wr;
  assign bus.mem_read    = !reset && mrd;
  assign bus.mem_write   = !reset && mwr;
  assign bus.reg_write   = !reset && reg_wr;
  assign bus.mem_to_reg  = !reset && m2r;
  assign bus.instr_done  = !reset && done;
  assign bus.exc         = !reset && exc_c;
  assign bus.state_dbg   = reset ? 4'd0 : state;
  assign bus.mem_timeout = !reset && (timeout_q || (mem_wait && wait_cnt == WAIT_MAX));

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, R-type, LDUR stall, CBZ, STUR timeout, illegal opcode.
module tb_multicycle_control;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_if bus ();

  multicycle_control #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] outs();
    return {bus.ALUControl, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.pc_src,
            bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.mem_to_reg,
            bus.instr_done, bus.mem_timeout, bus.exc, bus.state_dbg};
  endfunction

  // Advance to the next negedge, apply mem_ready, then let combinational outputs settle.
  task automatic cyc(input logic rdy);
    @(negedge clk);
    bus.mem_ready = rdy;
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 11'b0;
    bus.zero      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("reset_outs", 32'(outs()), 32'd0);
    end

    // SUB: FETCH, DECODE, EXEC_R, R_WB
    @(negedge clk);
    reset      = 1'b0;
    bus.opcode = 11'b11001011000;
    #1;
    chk("fetch_state", 32'(bus.state_dbg), 32'd0);
    chk("fetch_mem_read", 32'(bus.mem_read), 32'd1);
    chk("fetch_alu", 32'(bus.ALUControl), 32'h2);
    chk("fetch_ir_write", 32'(bus.ir_write), 32'd1);
    chk("fetch_pc_write", 32'(bus.pc_write), 32'd1);
    chk("fetch_src_b", 32'(bus.alu_src_b), 32'd1);
    cyc(1'b1);
    chk("sub_decode_state", 32'(bus.state_dbg), 32'd1);
    chk("sub_decode_src_b", 32'(bus.alu_src_b), 32'd3);
    chk("sub_decode_alu", 32'(bus.ALUControl), 32'h2);
    cyc(1'b1);
    chk("sub_exec_state", 32'(bus.state_dbg), 32'd2);
    chk("sub_exec_alu", 32'(bus.ALUControl), 32'h6);
    chk("sub_exec_src_a", 32'(bus.alu_src_a), 32'd1);
    chk("sub_exec_reg_write", 32'(bus.reg_write), 32'd0);
    chk("sub_exec_done", 32'(bus.instr_done), 32'd0);
    cyc(1'b1);
    chk("sub_wb_state", 32'(bus.state_dbg), 32'd3);
    chk("sub_wb_reg_write", 32'(bus.reg_write), 32'd1);
    chk("sub_wb_done", 32'(bus.instr_done), 32'd1);
    chk("sub_wb_m2r", 32'(bus.mem_to_reg), 32'd0);

    // LDUR with 3 stall cycles in MEM_RD: 8 cycles total
    @(negedge clk);
    bus.opcode = 11'b11111000010;
    #1;
    chk("ld_fetch_state", 32'(bus.state_dbg), 32'd0);
    chk("ld_fetch_done", 32'(bus.instr_done), 32'd0);
    cyc(1'b1);
    chk("ld_decode_state", 32'(bus.state_dbg), 32'd1);
    cyc(1'b0);
    chk("ld_addr_state", 32'(bus.state_dbg), 32'd4);
    chk("ld_addr_src_b", 32'(bus.alu_src_b), 32'd2);
    chk("ld_addr_src_a", 32'(bus.alu_src_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3);
      chk("ld_memrd_state", 32'(bus.state_dbg), 32'd5);
      chk("ld_memrd_read", 32'(bus.mem_read), 32'd1);
    end
    cyc(1'b1);
    chk("ld_wb_state", 32'(bus.state_dbg), 32'd6);
    chk("ld_wb_reg_write", 32'(bus.reg_write), 32'd1);
    chk("ld_wb_m2r", 32'(bus.mem_to_reg), 32'd1);
    chk("ld_wb_done", 32'(bus.instr_done), 32'd1);

    // CBZ taken (zero=1) then not taken (zero=0)
    for (int z = 1; z >= 0; z--) begin
      @(negedge clk);
      bus.opcode = 11'b10110100000;
      bus.zero   = z[0];
      #1;
      chk("cbz_fetch_state", 32'(bus.state_dbg), 32'd0);
      cyc(1'b1);
      chk("cbz_decode_state", 32'(bus.state_dbg), 32'd1);
      cyc(1'b1);
      chk("cbz_ex_state", 32'(bus.state_dbg), 32'd8);
      chk("cbz_ex_alu", 32'(bus.ALUControl), 32'h7);
      chk("cbz_ex_pc_src", 32'(bus.pc_src), 32'd1);
      chk("cbz_ex_pc_write", 32'(bus.pc_write), 32'(z));
      chk("cbz_ex_done", 32'(bus.instr_done), 32'd1);
    end

    // STUR with mem_ready low for 20 cycles: timeout visible on the 16th waiting cycle
    @(negedge clk);
    bus.opcode = 11'b11111000000;
    #1;
    chk("st_fetch_state", 32'(bus.state_dbg), 32'd0);
    cyc(1'b1);
    chk("st_decode_state", 32'(bus.state_dbg), 32'd1);
    cyc(1'b1);
    chk("st_addr_state", 32'(bus.state_dbg), 32'd4);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0);
      if (k == 1) begin
        chk("st_memwr_state", 32'(bus.state_dbg), 32'd7);
        chk("st_memwr_write", 32'(bus.mem_write), 32'd1);
        chk("st_memwr_done", 32'(bus.instr_done), 32'd0);
      end
      if (k == 15) chk("st_timeout_before", 32'(bus.mem_timeout), 32'd0);
      if (k == 16) chk("st_timeout_rise", 32'(bus.mem_timeout), 32'd1);
    end
    chk("st_still_waiting", 32'(bus.state_dbg), 32'd7);
    cyc(1'b1);
    chk("st_complete_done", 32'(bus.instr_done), 32'd1);
    chk("st_complete_state", 32'(bus.state_dbg), 32'd7);
    chk("st_timeout_held", 32'(bus.mem_timeout), 32'd1);
    cyc(1'b1);
    chk("st_after_state", 32'(bus.state_dbg), 32'd0);
    chk("st_after_timeout", 32'(bus.mem_timeout), 32'd1);

    // Reset mid-instruction clears everything, including the sticky timeout
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst2_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    bus.opcode = 11'b00000000000;
    #1;
    chk("rst2_fetch_state", 32'(bus.state_dbg), 32'd0);
    chk("rst2_timeout_clear", 32'(bus.mem_timeout), 32'd0);

    // Illegal opcode
    cyc(1'b1);
    chk("ill_decode_state", 32'(bus.state_dbg), 32'd1);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    chk("ill_decode_done", 32'(bus.instr_done), 32'd0);
    cyc(1'b1);
    chk("ill_trap_state", 32'(bus.state_dbg), 32'd9);
    chk("ill_trap_exc", 32'(bus.exc), 32'd1);
    chk("ill_trap_pc_src", 32'(bus.pc_src), 32'd2);
    chk("ill_trap_pc_write", 32'(bus.pc_write), 32'd1);
    chk("ill_trap_done", 32'(bus.instr_done), 32'd1);
`else
    chk("ill_decode_done", 32'(bus.instr_done), 32'd1);
    chk("ill_decode_exc", 32'(bus.exc), 32'd0);
`endif
    cyc(1'b1);
    chk("ill_back_fetch", 32'(bus.state_dbg), 32'd0);
    chk("ill_back_exc", 32'(bus.exc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM control unit for the multicycle LEGv8 datapath.
- Drives the ALU's 4-bit ALUControl and source-select muxes each cycle, and consumes the ALU's zero flag for CBZ.
- Sequences fetch/decode/execute/memory/writeback over 3–5+ cycles per instruction.
- Handshakes with a variable-latency unified memory via mem_ready.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles any memory state may wait for mem_ready before mem_timeout is raised.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  11  instr[31:21] from instruction register; stable from DECODE until the next FETCH
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current read/write this cycle
- ALUControl  output  4  ALU operation: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-b
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = register B, 01 = const 4, 10 = sign-extended D-imm, 11 = CB-offset<<2
- pc_write  output  1  PC register load enable
- pc_src  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = trap vector
- ir_write  output  1  instruction register load enable
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = memory data register
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- mem_timeout  output  1  sticky error flag
- exc  output  1  illegal-opcode trap pulse
- state_dbg  output  4  current state encoding

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, R_WB=3, ADDR=4, MEM_RD=5, LD_WB=6, MEM_WR=7, CBZ_EX=8, TRAP=9.
- Reset:
  - While reset=1, every output is 0, including ALUControl=0000 and state_dbg=0.
  - The state register loads FETCH; the wait counter and mem_timeout clear.
  - The first cycle after reset deasserts is FETCH.
  - Reset mid-instruction aborts it; no write enables are asserted during the reset cycle.
- Default: any output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, ALUControl=0010.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ALUControl=0010 (branch target into ALUOut). Next state by opcode:
  - 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR → EXEC_R
  - 11111000010 LDUR, 11111000000 STUR → ADDR
  - 10110100xxx CBZ → CBZ_EX
  - Anything else is illegal; see Optional Feature.
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUControl = ADD→0010, SUB→0110, AND→0000, ORR→0001; go to R_WB.
- R_WB: reg_write=1, mem_to_reg=0, instr_done=1; go to FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, ALUControl=0010; go to MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: mem_read=1; wait for mem_ready, then go to LD_WB.
- LD_WB: reg_write=1, mem_to_reg=1, instr_done=1; go to FETCH.
- MEM_WR: mem_write=1; wait for mem_ready, then instr_done=1 in that cycle and go to FETCH.
- CBZ_EX: alu_src_a=1, alu_src_b=00, ALUControl=0111, pc_src=01, pc_write=zero, instr_done=1; go to FETCH.
- Memory wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR; increments each cycle spent waiting.
  - Saturates at MEM_WAIT_MAX.
  - When the count equals MEM_WAIT_MAX with mem_ready=0, mem_timeout sets and holds until reset.
  - The FSM keeps waiting; mem_timeout does not change the state flow.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Latency in cycles with mem_ready=1 on first request: R-type 4, LDUR 5, STUR 4, CBZ 3.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: illegal opcode in DECODE goes to TRAP. TRAP asserts exc=1, pc_write=1, pc_src=10, instr_done=1 for one cycle, then goes to FETCH.
- Undefined: illegal opcode is a NOP. DECODE asserts instr_done=1 and goes to FETCH. State 9 is unreachable, exc is tied 0, and pc_src never equals 10.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 → all outputs 0 during reset; the cycle after release shows state_dbg=0, mem_read=1, ALUControl=0010, ir_write=1, pc_write=1.
- opcode=11001011000 (SUB), mem_ready=1 → state_dbg 0,1,2,3,0; ALUControl=0110 in EXEC_R; reg_write=1 and instr_done=1 only in R_WB.
- opcode=11111000010 (LDUR), mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles; LD_WB shows reg_write=1, mem_to_reg=1; total 8 cycles.
- opcode=10110100000 (CBZ), with zero=1 and separately with zero=0 → CBZ_EX shows ALUControl=0111 and pc_src=01; pc_write=1 only when zero=1.
- STUR with mem_ready held 0 for 20 cycles (MEM_WAIT_MAX=15) → mem_timeout rises after 15 waiting cycles and stays 1 after mem_ready returns; cleared only by reset.
- opcode=00000000000 → with MULTICYCLE_ILLEGAL_TRAP_EN: TRAP cycle with exc=1, pc_src=10, pc_write=1; without it: DECODE→FETCH with instr_done=1 and exc=0.
